// File: rtl/apb_fifo_slave_p.sv
// rtl/apb_fifo_slave_p.sv - APB slave with a buffered write FIFO and ordered arbiter reads
// Writes are queued as {addr, data} and drained via valid/ack; reads wait for the queue to empty.
module apb_fifo_slave_p #(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 32,
   parameter int                FIFO_DEPTH = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter logic [ADDR_W:0]   ADDR_SPAN  = 'h1000,
   parameter int                TIMEOUT    = 16,
   parameter int                LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              wr_valid_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   input  logic              wr_ack_i,
   output logic              rd_req_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic              arb_rdata_ack,
   input  logic [DATA_W-1:0] arb_rdata,
   output logic              full_o,
   output logic              empty_o,
   output logic [LVL_W-1:0]  fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ACCESS_W, DRAIN_R, WAIT_R, RESP} state_t;

   state_t              state, state_nxt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic                tmo_hit;
   logic [ADDR_W:0]     addr_off;
   logic                addr_err;
   logic                push, pop, capture;
   logic [DATA_W-1:0]   rdata_q;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [LVL_W-1:0]    level_q, level_nxt;
   logic                full_q, empty_q;
   logic [ADDR_W-1:0]   mem_addr [FIFO_DEPTH];
   logic [DATA_W-1:0]   mem_data [FIFO_DEPTH];

   // An address below BASE_ADDR borrows into the top bit, so one compare covers both ends.
   assign addr_off = {1'b0, PADDR} - {1'b0, BASE_ADDR};
   assign addr_err = (addr_off >= ADDR_SPAN);
   assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT));
   assign pop      = ~empty_q & wr_ack_i;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (PSEL && !PENABLE) state_nxt = PWRITE ? ACCESS_W : DRAIN_R;
         ACCESS_W: if (!PSEL || PREADY) state_nxt = IDLE;
         DRAIN_R: begin
            if (!PSEL || PSLVERR) state_nxt = IDLE;
            else if (capture)     state_nxt = RESP;
            else if (empty_q)     state_nxt = WAIT_R;
         end
         WAIT_R: begin
            if (!PSEL || PSLVERR) state_nxt = IDLE;
            else if (capture)     state_nxt = RESP;
         end
         RESP:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      PREADY   = 1'b0;
      PSLVERR  = 1'b0;
      rd_req_o = 1'b0;
      push     = 1'b0;
      capture  = 1'b0;
      unique case (state)
         ACCESS_W: if (PSEL) begin
            if (addr_err || tmo_hit) begin
               PREADY  = 1'b1;
               PSLVERR = 1'b1;
            end else if (!full_q) begin
               PREADY = 1'b1;
               push   = 1'b1;
            end
         end
         DRAIN_R, WAIT_R: if (PSEL) begin
            if (addr_err || tmo_hit) begin
               PREADY  = 1'b1;
               PSLVERR = 1'b1;
            end else if (state == WAIT_R || empty_q) begin
               rd_req_o = 1'b1;
               capture  = arb_rdata_ack;
            end
         end
         RESP:    PREADY = 1'b1;
         default: ;
      endcase
   end

   // Read data is cleared at setup so an error or timeout response returns zero.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         tmo_cnt <= '0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE) tmo_cnt <= '0;
         else               tmo_cnt <= tmo_cnt + 1'b1;
         if (state == IDLE && PSEL && !PENABLE) rdata_q <= '0;
         else if (capture)                      rdata_q <= arb_rdata;
      end
   end

   always_comb begin
      level_nxt = level_q;
      if (push && !pop)      level_nxt = level_q + 1'b1;
      else if (!push && pop) level_nxt = level_q - 1'b1;
   end

   always_ff @(posedge PCLK) begin
      if (push) begin
         mem_addr[wr_ptr] <= PADDR;
         mem_data[wr_ptr] <= PWDATA;
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level_q <= level_nxt;
         full_q  <= (level_nxt == LVL_W'(FIFO_DEPTH));
         empty_q <= (level_nxt == '0);
      end
   end

   assign PRDATA     = rdata_q;
   assign rd_addr_o  = PADDR;
   assign wr_valid_o = ~empty_q;
   assign wr_addr_o  = mem_addr[rd_ptr];
   assign wr_data_o  = mem_data[rd_ptr];
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_apb_fifo_slave_p.sv
// tb/tb_apb_fifo_slave_p.sv - scoreboard bench for apb_fifo_slave_p
// APB responses and FIFO pops are checked by monitors against queues filled by the stimulus.
module tb_apb_fifo_slave_p;

   logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic        wr_valid_o, wr_ack_i, rd_req_o, arb_rdata_ack;
   logic [31:0] wr_addr_o, wr_data_o, rd_addr_o, arb_rdata;
   logic        full_o, empty_o;
   logic [3:0]  fifo_level;

   typedef struct packed {
      logic        err;
      logic        dchk;
      logic [31:0] data;
   } rsp_t;

   rsp_t        exp_rsp [$];
   logic [63:0] exp_wq  [$];
   rsp_t        mon_r;
   logic [63:0] mon_w;
   int          checks = 0;
   int          errors = 0;
   int          w;

   apb_fifo_slave_p dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_ack_i(wr_ack_i),
      .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .arb_rdata_ack(arb_rdata_ack),
      .arb_rdata(arb_rdata), .full_o(full_o), .empty_o(empty_o), .fifo_level(fifo_level)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge PCLK) begin
      if (PRESET && PSEL && PENABLE && PREADY) begin
         if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
         else begin
            mon_r = exp_rsp.pop_front();
            check("rsp_pslverr", PSLVERR, mon_r.err);
            if (mon_r.dchk) check("rsp_prdata", PRDATA, mon_r.data);
         end
      end
   end

   always @(negedge PCLK) begin
      if (PRESET && wr_valid_o && wr_ack_i) begin
         if (exp_wq.size() == 0) check("unexpected_pop", 1, 0);
         else begin
            mon_w = exp_wq.pop_front();
            check("pop_entry", {wr_addr_o, wr_data_o}, mon_w);
         end
      end
   end

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic exp_err,
                            input int ack_at, output int waits);
      exp_rsp.push_back('{err: exp_err, dchk: 1'b0, data: 32'h0});
      if (!exp_err) exp_wq.push_back({a, d});
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits = 0;
      forever begin
         @(negedge PCLK);
         if (ack_at >= 0) wr_ack_i = 1'b0;
         if (PREADY) break;
         if (waits == ack_at) wr_ack_i = 1'b1;
         waits++;
         if (waits > 100) begin
            check("write_bound", 1, 0);
            break;
         end
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, input int ack_delay, input logic [31:0] rd,
                           input logic exp_err, input logic [31:0] exp_data, output int waits);
      int nreq;
      exp_rsp.push_back('{err: exp_err, dchk: 1'b1, data: exp_data});
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits = 0;
      nreq  = 0;
      forever begin
         @(negedge PCLK);
         arb_rdata_ack = 1'b0;
         if (PREADY) break;
         if (rd_req_o) begin
            check("rd_req_when_empty", empty_o, 1);
            check("rd_addr", rd_addr_o, a);
            if (nreq == ack_delay) begin
               arb_rdata_ack = 1'b1;
               arb_rdata     = rd;
            end
            nreq++;
         end
         waits++;
         if (waits > 100) begin
            check("read_bound", 1, 0);
            break;
         end
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; wr_ack_i = 1'b0; arb_rdata_ack = 1'b0; arb_rdata = '0;
      #12;
      check("rst_prdata", PRDATA, 0);
      check("rst_pready", PREADY, 0);
      check("rst_pslverr", PSLVERR, 0);
      check("rst_wr_valid", wr_valid_o, 0);
      check("rst_rd_req", rd_req_o, 0);
      check("rst_full", full_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_level", fifo_level, 0);
      @(posedge PCLK); #1;
      PRESET = 1'b1;

      // four zero-wait writes, no drain
      apb_write(32'h0, 32'hA0, 1'b0, -1, w); check("w0_waits", w, 0);
      apb_write(32'h4, 32'hA1, 1'b0, -1, w); check("w1_waits", w, 0);
      apb_write(32'h8, 32'hA2, 1'b0, -1, w); check("w2_waits", w, 0);
      apb_write(32'hC, 32'hA3, 1'b0, -1, w); check("w3_waits", w, 0);
      @(negedge PCLK);
      check("lvl4", fifo_level, 4);
      check("wr_valid4", wr_valid_o, 1);
      check("head_addr", wr_addr_o, 32'h0);
      check("head_data", wr_data_o, 32'hA0);

      // fill to 8, then a blocked 9th write released by one pop
      apb_write(32'h10, 32'hA4, 1'b0, -1, w); check("w4_waits", w, 0);
      apb_write(32'h14, 32'hA5, 1'b0, -1, w); check("w5_waits", w, 0);
      apb_write(32'h18, 32'hA6, 1'b0, -1, w); check("w6_waits", w, 0);
      apb_write(32'h1C, 32'hA7, 1'b0, -1, w); check("w7_waits", w, 0);
      @(negedge PCLK);
      check("lvl8", fifo_level, 8);
      check("full8", full_o, 1);
      apb_write(32'h20, 32'hA8, 1'b0, 2, w);
      check("w8_full_waits", w, 3);
      @(negedge PCLK);
      check("lvl8_after", fifo_level, 8);
      check("full_after", full_o, 1);
      check("head_after_pop", wr_addr_o, 32'h4);

      // write then read: read waits until the FIFO drains
      @(posedge PCLK); #1; wr_ack_i = 1'b1;
      repeat (2) @(posedge PCLK);
      #1; wr_ack_i = 1'b0;
      @(negedge PCLK);
      check("lvl6", fifo_level, 6);
      apb_write(32'h24, 32'h55, 1'b0, -1, w); check("w55_waits", w, 0);
      wr_ack_i = 1'b1;
      apb_read(32'h30, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, w);
      wr_ack_i = 1'b0;
      @(negedge PCLK);
      check("drained_empty", empty_o, 1);
      check("drained_lvl", fifo_level, 0);
      check("all_popped", exp_wq.size(), 0);

      // reads on an empty FIFO: ack latency adds wait states
      apb_read(32'h34, 0, 32'h12345678, 1'b0, 32'h12345678, w); check("rd_ack0_waits", w, 1);
      apb_read(32'h38, 2, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, w); check("rd_ack2_waits", w, 3);

      // timeout: no ack ever
      apb_read(32'h3C, -1, 32'h0, 1'b1, 32'h0, w);
      check("tmo_waits", w, 16);
      @(negedge PCLK);
      check("tmo_rd_req_drop", rd_req_o, 0);
      arb_rdata = 32'h99999999; arb_rdata_ack = 1'b1;
      @(negedge PCLK);
      arb_rdata_ack = 1'b0;
      check("late_ack_ignored", PRDATA, 0);

      // decode errors at the top of the range, last valid address accepted
      apb_write(32'h1000, 32'h77, 1'b1, -1, w); check("dec_w_waits", w, 0);
      @(negedge PCLK);
      check("dec_w_lvl", fifo_level, 0);
      apb_read(32'h1000, 0, 32'h11, 1'b1, 32'h0, w); check("dec_r_waits", w, 0);
      apb_write(32'hFFC, 32'h66, 1'b0, -1, w); check("last_addr_waits", w, 0);
      @(negedge PCLK);
      check("last_addr_lvl", fifo_level, 1);
      @(posedge PCLK); #1; wr_ack_i = 1'b1;
      @(posedge PCLK); #1; wr_ack_i = 1'b0;
      @(negedge PCLK);
      check("rsp_all_seen", exp_rsp.size(), 0);
      check("wq_all_seen", exp_wq.size(), 0);

      // reset in the middle of a read with three entries buffered
      apb_write(32'h40, 32'hB0, 1'b0, -1, w);
      apb_write(32'h44, 32'hB1, 1'b0, -1, w);
      apb_write(32'h48, 32'hB2, 1'b0, -1, w);
      @(negedge PCLK);
      check("pre_rst_lvl", fifo_level, 3);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h50;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      check("pre_rst_no_req", rd_req_o, 0);
      #2;
      PRESET = 1'b0;
      #1;
      check("mrst_prdata", PRDATA, 0);
      check("mrst_pready", PREADY, 0);
      check("mrst_pslverr", PSLVERR, 0);
      check("mrst_wr_valid", wr_valid_o, 0);
      check("mrst_rd_req", rd_req_o, 0);
      check("mrst_full", full_o, 0);
      check("mrst_empty", empty_o, 1);
      check("mrst_level", fifo_level, 0);
      PSEL = 1'b0; PENABLE = 1'b0;
      exp_wq.delete();
      exp_rsp.delete();
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      @(negedge PCLK);
      check("post_rst_pready", PREADY, 0);
      check("post_rst_wr_valid", wr_valid_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
